// File: rtl/exu_lsu.sv
// Load/store unit for the execute stage: byte/half/word/double accesses over a
// valid/ready memory request channel, with sign/zero extension of load data.
module exu_lsu #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_store,
    input  logic [2:0]          in_funct3,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic                out_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int LANE_W = $clog2(STRB_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_store;
    logic [2:0]             r_funct3;
    logic [LANE_W-1:0]      r_lane;
    logic [XLEN-1:0]        r_mem_addr;
    logic                   r_mem_we;
    logic [STRB_W-1:0]      r_mem_wstrb;
    logic [XLEN-1:0]        r_mem_wdata;
    logic [XLEN-1:0]        r_out_data;
    logic                   r_out_err;

    logic                   w_illegal;
    logic [XLEN-1:0]        w_aligned;
    logic [LANE_W+2:0]      w_in_shift;
    logic [LANE_W+2:0]      w_rd_shift;

    // Misalignment, sizes absent at this XLEN, the reserved code, and
    // unsigned-store encodings all fail without touching memory.
    function automatic logic is_illegal(input logic st, input logic [2:0] f3,
                                        input logic [2:0] a_lo);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b100:  bad = 1'b0;
            3'b001:  bad = a_lo[0];
            3'b101:  bad = a_lo[0];
            3'b010:  bad = (a_lo[1:0] != 2'b00);
            3'b110:  bad = (XLEN == 32) || (a_lo[1:0] != 2'b00);
            3'b011:  bad = (XLEN == 32) || (a_lo != 3'b000);
            default: bad = 1'b1;
        endcase
        return bad || (st && f3[2]);
    endfunction

    function automatic logic [STRB_W-1:0] size_strb(input logic [1:0] sz);
        logic [STRB_W-1:0] s;
        case (sz)
            2'b00:   s = STRB_W'(4'h1);
            2'b01:   s = STRB_W'(4'h3);
            2'b10:   s = STRB_W'(4'hF);
            default: s = '1;
        endcase
        return s;
    endfunction

    // Truncate lane-aligned read data to the access size and extend it;
    // the sign bit is located as the top set bit of the size mask.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] d);
        logic [XLEN-1:0] ones;
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] sbit;
        logic [XLEN-1:0] r;
        ones = '1;
        case (f3[1:0])
            2'b00:   mask = ones >> (XLEN - 8);
            2'b01:   mask = ones >> (XLEN - 16);
            2'b10:   mask = ones >> (XLEN - 32);
            default: mask = ones;
        endcase
        sbit = mask & ~(mask >> 1);
        r    = d & mask;
        return (!f3[2] && (|(d & sbit))) ? (r | ~mask) : r;
    endfunction

    // Request-side decode of the incoming operation.
    always_comb begin
        w_illegal  = is_illegal(in_store, in_funct3, in_addr[2:0]);
        w_aligned  = in_addr;
        w_aligned[LANE_W-1:0] = '0;
        w_in_shift = {in_addr[LANE_W-1:0], 3'b000};
        w_rd_shift = {r_lane, 3'b000};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = w_illegal ? S_RESP : S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    w_next = S_WAIT;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only.
    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (r_state)
            S_IDLE:  in_ready      = 1'b1;
            S_REQ:   mem_req_valid = 1'b1;
            S_WAIT:  mem_req_valid = 1'b0;
            S_RESP:  out_valid     = 1'b1;
            default: in_ready      = 1'b0;
        endcase
    end

    // Operation latch at accept and result capture on the memory response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store     <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_store    <= in_store;
                        r_funct3   <= in_funct3;
                        r_lane     <= in_addr[LANE_W-1:0];
                        r_out_data <= '0;
                        r_out_err  <= w_illegal;
                        if (w_illegal) begin
                            r_mem_addr  <= '0;
                            r_mem_we    <= 1'b0;
                            r_mem_wstrb <= '0;
                            r_mem_wdata <= '0;
                        end else begin
                            r_mem_addr  <= w_aligned;
                            r_mem_we    <= in_store;
                            r_mem_wstrb <= in_store ?
                                (size_strb(in_funct3[1:0]) << in_addr[LANE_W-1:0]) : '0;
                            r_mem_wdata <= in_store ? (in_wdata << w_in_shift) : '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_out_data <= r_store ? '0 :
                                      load_ext(r_funct3, mem_rdata >> w_rd_shift);
                    end
                end
                default: begin
                    r_out_err <= r_out_err;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;

endmodule
